hsv_to_rgb: RTL and testbench
=============================

# hsv_to_rgb

Pipelined HSV-to-RGB converter for the 10-bit skin-detection video path: the inverse of the RGB min/max/hue front end. It takes one HSV pixel per enabled cycle and produces the matching 10-bit R/G/B triple. It also produces the minimum channel value and its channel index, using the same 0 = red, 1 = green, 2 = blue encoding as the `min` block, so downstream logic can cross-check a round trip. It sits after the neuro classifier and re-renders classified or modified pixels for display.

## Interface
- No parameters. All widths are fixed: channels are 10 bits, hue is 11 bits.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `ce`  in  1  clock enable; when low, the entire pipeline holds.
- `in_valid`  in  1  the H/S/V inputs carry a pixel this cycle.
- `hue`  in  11  hue, 0..1535, six sectors of 256 steps each; values ≥1536 are clamped to 1535.
- `sat`  in  10  saturation, 0..1023.
- `val`  in  10  value (the maximum channel), 0..1023.
- `out_valid`  out  1  the outputs below carry a converted pixel.
- `red`, `green`, `blue`  out  10 each  converted channels.
- `min_value`  out  10  smallest channel, equal to p.
- `min_index`  out  2  channel holding p: 0 = R, 1 = G, 2 = B; the value 3 is never produced.

## Operation
Internal terms:
- `h = min(hue, 1535)`, `sector = h[10:8]` (0..5), `f = h[7:0]`.
- `vs = val*sat` (20 bits, unsigned).
- `p = val - vs[19:10]`.
- `q = val - ((vs*f) >> 18)`.
- `t = val - ((vs*(256-f)) >> 18)`. The product is 29 bits.

Width rules:
- All subtrahends are ≤ `val`, so there is no underflow and no saturation logic.
- The shifted results fit in 10 bits; truncate, do not round.

Sector mapping to (R,G,B) and min_index:
- 0: (V,t,p), index 2.
- 1: (q,V,p), index 2.
- 2: (p,V,t), index 0.
- 3: (p,q,V), index 0.
- 4: (t,p,V), index 1.
- 5: (V,p,q), index 1.

Pipeline, three register stages; each advances only when `ce` = 1:
- S1: register `val`, `sector`, `f`, `in_valid`; compute and register `vs`.
- S2: register `p`, `vs*f`, `vs*(256-f)`, `val`, `sector`, valid.
- S3: compute q and t, apply the sector mux, register all outputs and `out_valid`.

Invalid-pixel handling:
- When `in_valid` = 0, the valid bit propagates as 0.
- Data registers may load arbitrary values in that case.
- The output data registers are updated only when the S3 valid bit is 1. Outputs therefore hold the last valid pixel while `out_valid` = 0.

## Timing
- Latency is exactly 3 enabled cycles from input sample to outputs.
  - A pixel presented with `in_valid` = 1 at enabled edge N appears with `out_valid` = 1 after enabled edge N+2.
  - It is visible during the cycle following that edge.
- Throughput is one pixel per enabled cycle. There is no backpressure port; the consumer must accept every `out_valid`.
- `ce` = 0: every register, including valid bits, holds, and outputs are stable. Cycles with `ce` low do not count toward latency.
- `rst` = 1 at a rising edge, regardless of `ce`:
  - All valid bits clear.
  - `red`, `green`, `blue`, `min_value` reset to 0; `min_index` resets to 0; `out_valid` resets to 0.
- Reset mid-stream discards all in-flight pixels. The first `in_valid` after reset is released emerges 3 enabled cycles later.
- `rst` and `ce` together: reset wins.
- Back-to-back pixels with alternating sectors must not cross-contaminate. Each stage carries its own sector and f.

## Test plan
- Grey pixel: reset, then `ce` = 1, `val` = 1023, `sat` = 0, `hue` = 700 -> exactly 3 cycles later `out_valid` = 1, RGB = (1023,1023,1023), `min_value` = 1023, `min_index` = 0.
- Primary hues: `val` = 1023, `sat` = 1023.
  - `hue` = 0 -> (1023,1,1), index 2.
  - `hue` = 256 -> (1023,1023,1).
  - `hue` = 512 -> (1,1023,1), index 0.
  - `hue` = 1024 -> (1,1,1023), index 1.
- Fractional sector: `val` = 512, `sat` = 512, `hue` = 128 -> (512,384,256), `min_value` = 256, `min_index` = 2.
- Clamp and streaming:
  - `hue` = 2000 gives the same result as `hue` = 1535.
  - Six back-to-back pixels, one per sector, emerge in order on six consecutive cycles, each matching the reference model.
- Stall and reset:
  - Drop `ce` for 4 cycles mid-stream -> outputs and `out_valid` frozen; the stream resumes with total latency 3 enabled cycles.
  - Assert `rst` with 2 pixels in flight -> `out_valid` stays 0, all outputs read 0.
- Random regression: 10k random (H,S,V) with random `ce` gaps -> bit-exact match to the integer model above, and `min_value` equals the minimum of the three channels.

Source files
------------

// File: rtl/hsv_to_rgb.sv
// Three-stage HSV-to-RGB converter for the 10-bit skin-detection video path.
// Besides R/G/B it reports the minimum channel and which channel holds it.
module hsv_to_rgb (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        in_valid,
    input  logic [10:0] hue,
    input  logic [9:0]  sat,
    input  logic [9:0]  val,
    output logic        out_valid,
    output logic [9:0]  red,
    output logic [9:0]  green,
    output logic [9:0]  blue,
    output logic [9:0]  min_value,
    output logic [1:0]  min_index
);

    logic [10:0] h_clamped;

    logic        s1_valid;
    logic [9:0]  s1_val;
    logic [2:0]  s1_sector;
    logic [7:0]  s1_f;
    logic [19:0] s1_vs;
    logic [8:0]  f_comp;

    logic        s2_valid;
    logic [9:0]  s2_val;
    logic [2:0]  s2_sector;
    logic [9:0]  s2_p;
    logic [27:0] s2_prod_q;
    logic [28:0] s2_prod_t;

    logic [9:0]  q_term;
    logic [9:0]  t_term;
    logic [9:0]  mux_r;
    logic [9:0]  mux_g;
    logic [9:0]  mux_b;
    logic [9:0]  mux_min;
    logic [1:0]  mux_idx;

    assign h_clamped = (hue > 11'd1535) ? 11'd1535 : hue;
    assign f_comp    = 9'd256 - {1'b0, s1_f};

    // Stage 1: split hue into sector/fraction and form val*sat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (ce) begin
            s1_valid  <= in_valid;
            s1_val    <= val;
            s1_sector <= h_clamped[10:8];
            s1_f      <= h_clamped[7:0];
            s1_vs     <= 20'(val) * 20'(sat);
        end
    end

    // Stage 2: p and the two fractional products; sector and val travel along.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else if (ce) begin
            s2_valid  <= s1_valid;
            s2_val    <= s1_val;
            s2_sector <= s1_sector;
            s2_p      <= s1_val - s1_vs[19:10];
            s2_prod_q <= 28'(s1_vs) * 28'(s1_f);
            s2_prod_t <= 29'(s1_vs) * 29'(f_comp);
        end
    end

    assign q_term = s2_val - 10'(s2_prod_q >> 18);
    assign t_term = s2_val - 10'(s2_prod_t >> 18);

    // Sector mux; p is always the minimum, so its slot gives the min index.
    always_comb begin
        mux_r   = s2_val;
        mux_g   = s2_p;
        mux_b   = q_term;
        mux_min = s2_p;
        mux_idx = 2'd1;
        case (s2_sector)
            3'd0: begin mux_r = s2_val; mux_g = t_term; mux_b = s2_p;   mux_idx = 2'd2; end
            3'd1: begin mux_r = q_term; mux_g = s2_val; mux_b = s2_p;   mux_idx = 2'd2; end
            3'd2: begin mux_r = s2_p;   mux_g = s2_val; mux_b = t_term; mux_idx = 2'd0; end
            3'd3: begin mux_r = s2_p;   mux_g = q_term; mux_b = s2_val; mux_idx = 2'd0; end
            3'd4: begin mux_r = t_term; mux_g = s2_p;   mux_b = s2_val; mux_idx = 2'd1; end
            default: begin mux_r = s2_val; mux_g = s2_p; mux_b = q_term; mux_idx = 2'd1; end
        endcase
    end

    // Stage 3: output data only loads for valid pixels so it holds between them.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            min_value <= '0;
            min_index <= '0;
        end else if (ce) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                red       <= mux_r;
                green     <= mux_g;
                blue      <= mux_b;
                min_value <= mux_min;
                min_index <= mux_idx;
            end
        end
    end

endmodule

// File: tb/tb_hsv_to_rgb.sv
// Scoreboard bench for hsv_to_rgb: an integer reference model predicts every
// output cycle, including latency, stalls, reset flushes and held data.
module tb_hsv_to_rgb;

    typedef struct {
        int r;
        int g;
        int b;
        int mv;
        int mi;
        int due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        in_valid = 1'b0;
    logic [10:0] hue = '0;
    logic [9:0]  sat = '0;
    logic [9:0]  val = '0;
    logic        out_valid;
    logic [9:0]  red;
    logic [9:0]  green;
    logic [9:0]  blue;
    logic [9:0]  min_value;
    logic [1:0]  min_index;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t last_data = '{0, 0, 0, 0, 0, 0};
    int   exp_ov = 0;
    int   edge_kind = 0;
    int   en_cnt = 0;
    int   last_idx = 0;
    bit   ovr_valid = 1'b0;
    exp_t ovr_exp = '{0, 0, 0, 0, 0, 0};

    hsv_to_rgb dut (
        .clk(clk),
        .rst(rst),
        .ce(ce),
        .in_valid(in_valid),
        .hue(hue),
        .sat(sat),
        .val(val),
        .out_valid(out_valid),
        .red(red),
        .green(green),
        .blue(blue),
        .min_value(min_value),
        .min_index(min_index)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int h_in, input int s, input int v);
        exp_t e;
        longint h, sec, f, vs, p, q, t;
        h   = (h_in > 1535) ? 1535 : h_in;
        sec = h / 256;
        f   = h % 256;
        vs  = v * s;
        p   = v - (vs >> 10);
        q   = v - ((vs * f) >> 18);
        t   = v - ((vs * (256 - f)) >> 18);
        e.mv  = int'(p);
        e.due = 0;
        case (sec)
            0: begin e.r = v;      e.g = int'(t); e.b = int'(p); e.mi = 2; end
            1: begin e.r = int'(q); e.g = v;      e.b = int'(p); e.mi = 2; end
            2: begin e.r = int'(p); e.g = v;      e.b = int'(t); e.mi = 0; end
            3: begin e.r = int'(p); e.g = int'(q); e.b = v;      e.mi = 0; end
            4: begin e.r = int'(t); e.g = int'(p); e.b = v;      e.mi = 1; end
            default: begin e.r = v; e.g = int'(p); e.b = int'(q); e.mi = 1; end
        endcase
        return e;
    endfunction

    task automatic check_output(input string tag, input int obs, input int exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Classify each edge and enqueue the expected result of every sampled pixel.
    always @(posedge clk) begin
        if (rst) begin
            edge_kind = 0;
            sb.delete();
        end else if (ce) begin
            edge_kind = 1;
            last_idx  = en_cnt;
            if (in_valid) begin
                exp_t e;
                e = ovr_valid ? ovr_exp : model(int'(hue), int'(sat), int'(val));
                e.due = en_cnt + 2;
                sb.push_back(e);
            end
            en_cnt++;
        end else begin
            edge_kind = 2;
        end
    end

    // Predict out_valid and the held data after each edge, then compare.
    always @(negedge clk) begin
        if (edge_kind == 0) begin
            exp_ov    = 0;
            last_data = '{0, 0, 0, 0, 0, 0};
        end else if (edge_kind == 1) begin
            while (sb.size() > 0 && sb[0].due < last_idx) void'(sb.pop_front());
            if (sb.size() > 0 && sb[0].due == last_idx) begin
                last_data = sb.pop_front();
                exp_ov    = 1;
            end else begin
                exp_ov = 0;
            end
        end
        check_output("out_valid", int'(out_valid), exp_ov);
        check_output("red", int'(red), last_data.r);
        check_output("green", int'(green), last_data.g);
        check_output("blue", int'(blue), last_data.b);
        check_output("min_value", int'(min_value), last_data.mv);
        check_output("min_index", int'(min_index), last_data.mi);
    end

    task automatic apply_stimulus(input int h, input int s, input int v,
                                  input bit vld, input bit c);
        @(negedge clk);
        hue       = 11'(h);
        sat       = 10'(s);
        val       = 10'(v);
        in_valid  = vld;
        ce        = c;
        ovr_valid = 1'b0;
    endtask

    task automatic apply_known(input int h, input int s, input int v,
                               input int r, input int g, input int b,
                               input int mv, input int mi);
        apply_stimulus(h, s, v, 1'b1, 1'b1);
        ovr_exp   = '{r, g, b, mv, mi, 0};
        ovr_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);

        apply_known(700, 0, 1023, 1023, 1023, 1023, 1023, 0);
        idle(4);

        apply_known(0, 1023, 1023, 1023, 1, 1, 1, 2);
        apply_known(256, 1023, 1023, 1023, 1023, 1, 1, 2);
        apply_known(512, 1023, 1023, 1, 1023, 1, 1, 0);
        apply_known(1024, 1023, 1023, 1, 1, 1023, 1, 1);
        apply_known(128, 512, 512, 512, 384, 256, 256, 2);
        idle(4);

        apply_stimulus(1535, 700, 800, 1'b1, 1'b1);
        apply_stimulus(2000, 700, 800, 1'b1, 1'b1);
        apply_stimulus(2047, 1023, 1023, 1'b1, 1'b1);
        idle(4);

        for (int s = 0; s < 6; s++)
            apply_stimulus(s * 256 + 37 + s * 31, 900 - s * 70, 1000 - s * 50, 1'b1, 1'b1);
        idle(4);

        apply_stimulus(100, 800, 900, 1'b1, 1'b1);
        apply_stimulus(400, 600, 700, 1'b1, 1'b1);
        apply_stimulus(900, 1000, 1000, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) apply_stimulus(1300, 500, 500, 1'b1, 1'b0);
        apply_stimulus(1400, 300, 1000, 1'b1, 1'b1);
        idle(5);

        apply_stimulus(300, 900, 900, 1'b1, 1'b1);
        apply_stimulus(1100, 900, 900, 1'b1, 1'b1);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(4);
        apply_stimulus(600, 1023, 1023, 1'b1, 1'b1);
        apply_stimulus(200, 400, 600, 1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        ce  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(4);

        for (int i = 0; i < 10000; i++)
            apply_stimulus(int'($urandom_range(2047)), int'($urandom_range(1023)),
                           int'($urandom_range(1023)),
                           ($urandom_range(3) != 0), ($urandom_range(4) != 0));
        idle(6);

        check_output("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
